// File: rtl/mult_reservation_station.sv
// mult_reservation_station
//   Reservation station in front of the multiplier. It holds up to RSsize
//   dispatched multiply operations in age order, using a collapsing queue
//   where slot 0 is the oldest. Missing source operands are captured from the
//   CDB by ROB tag. Each cycle the oldest entry whose two operands are both
//   ready is presented to the execute stage over a ready/stall handshake.
//
// Ports
//   clk_i, reset_i                    clock, async active-high reset
//   dispatch*_i                       new operation from dispatch/rename
//   full_o, count_o                   occupancy status (registered)
//   cdbValid_i, cdbTag_i, cdbVal_i    common data bus broadcast
//   flush_i                           synchronous clear of all entries
//   readyRS_o, reservationStation*_o  selected entry to the execute stage
//   stallRS_i                         execute stage cannot accept this cycle
module mult_reservation_station #(
  parameter int unsigned ROBsize    = 8,
  parameter int unsigned ROBsizeLog = $clog2(ROBsize + 1),
  parameter int unsigned RSsize     = 4
) (
  input  logic                         clk_i,
  input  logic                         reset_i,
  input  logic                         dispatchValid_i,
  input  logic [9:0]                   dispatchCommands_i,
  input  logic [ROBsizeLog-1:0]        dispatchTag_i,
  input  logic [63:0]                  dispatchVal1_i,
  input  logic [63:0]                  dispatchVal2_i,
  input  logic                         dispatchRdy1_i,
  input  logic                         dispatchRdy2_i,
  input  logic [ROBsizeLog-1:0]        dispatchSrc1_i,
  input  logic [ROBsizeLog-1:0]        dispatchSrc2_i,
  output logic                         full_o,
  output logic [$clog2(RSsize+1)-1:0] count_o,
  input  logic                         cdbValid_i,
  input  logic [ROBsizeLog-1:0]        cdbTag_i,
  input  logic [63:0]                  cdbVal_i,
  input  logic                         flush_i,
  output logic                         readyRS_o,
  output logic [63:0]                  reservationStationVal1_o,
  output logic [63:0]                  reservationStationVal2_o,
  output logic [9:0]                   reservationStationCommands_o,
  output logic [ROBsizeLog-1:0]        reservationStationTag_o,
  input  logic                         stallRS_i
);

  localparam int unsigned CNTW = $clog2(RSsize + 1);
  localparam int unsigned IDXW = (RSsize > 1) ? $clog2(RSsize) : 1;

  typedef struct packed {
    logic                  valid;
    logic [9:0]            cmd;
    logic [ROBsizeLog-1:0] tag;
    logic [63:0]           val1;
    logic                  rdy1;
    logic [ROBsizeLog-1:0] src1;
    logic [63:0]           val2;
    logic                  rdy2;
    logic [ROBsizeLog-1:0] src2;
  } entry_t;

  entry_t            ent_q [RSsize];
  entry_t            cap   [RSsize];
  entry_t            nxt   [RSsize];
  entry_t            disp;
  entry_t            sel_ent;
  logic [CNTW-1:0]   count_q;
  logic [CNTW-1:0]   count_d;
  logic [CNTW-1:0]   wpos;
  logic [IDXW-1:0]   sel_idx;
  logic              sel_found;
  logic              issue;
  logic              disp_acc;

  assign full_o   = (count_q == CNTW'(RSsize));
  assign count_o  = count_q;
  assign issue    = sel_found & ~stallRS_i;
  assign disp_acc = dispatchValid_i & ~full_o & ~flush_i;
  // Slot index of the first free entry once an issue shift has happened.
  assign wpos     = issue ? (count_q - CNTW'(1)) : count_q;

  // Oldest issuable entry: lowest slot with both operands ready.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int unsigned i = 0; i < RSsize; i++) begin
      if (!sel_found && ent_q[i].valid && ent_q[i].rdy1 && ent_q[i].rdy2) begin
        sel_found = 1'b1;
        sel_idx   = IDXW'(i);
      end
    end
  end

  assign sel_ent                      = ent_q[sel_idx];
  assign readyRS_o                    = sel_found;
  assign reservationStationVal1_o     = sel_found ? sel_ent.val1 : '0;
  assign reservationStationVal2_o     = sel_found ? sel_ent.val2 : '0;
  assign reservationStationCommands_o = sel_found ? sel_ent.cmd  : '0;
  assign reservationStationTag_o      = sel_found ? sel_ent.tag  : '0;

  // CDB capture on the current contents, before any shift, so entries that
  // move down this cycle still pick up the broadcast.
  always_comb begin
    for (int unsigned i = 0; i < RSsize; i++) begin
      cap[i] = ent_q[i];
      if (cdbValid_i && ent_q[i].valid && !ent_q[i].rdy1 && ent_q[i].src1 == cdbTag_i) begin
        cap[i].val1 = cdbVal_i;
        cap[i].rdy1 = 1'b1;
      end
      if (cdbValid_i && ent_q[i].valid && !ent_q[i].rdy2 && ent_q[i].src2 == cdbTag_i) begin
        cap[i].val2 = cdbVal_i;
        cap[i].rdy2 = 1'b1;
      end
    end
  end

  // Incoming entry, including the case where its producer is on the CDB now.
  always_comb begin
    disp.valid = 1'b1;
    disp.cmd   = dispatchCommands_i;
    disp.tag   = dispatchTag_i;
    disp.val1  = dispatchVal1_i;
    disp.rdy1  = dispatchRdy1_i;
    disp.src1  = dispatchSrc1_i;
    disp.val2  = dispatchVal2_i;
    disp.rdy2  = dispatchRdy2_i;
    disp.src2  = dispatchSrc2_i;
    if (cdbValid_i && !dispatchRdy1_i && dispatchSrc1_i == cdbTag_i) begin
      disp.val1 = cdbVal_i;
      disp.rdy1 = 1'b1;
    end
    if (cdbValid_i && !dispatchRdy2_i && dispatchSrc2_i == cdbTag_i) begin
      disp.val2 = cdbVal_i;
      disp.rdy2 = 1'b1;
    end
  end

  // Collapse above the issued slot, then append the dispatch at wpos.
  always_comb begin
    for (int unsigned i = 0; i + 1 < RSsize; i++) begin
      if (issue && i >= 32'(sel_idx)) nxt[i] = cap[i + 1];
      else                            nxt[i] = cap[i];
    end
    nxt[RSsize-1] = cap[RSsize-1];
    if (issue) nxt[RSsize-1].valid = 1'b0;
    for (int unsigned i = 0; i < RSsize; i++) begin
      if (disp_acc && CNTW'(i) == wpos) nxt[i] = disp;
      if (flush_i) nxt[i].valid = 1'b0;
    end
  end

  always_comb begin
    if (flush_i) count_d = '0;
    else         count_d = count_q + CNTW'(disp_acc) - CNTW'(issue);
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      count_q <= '0;
      for (int unsigned i = 0; i < RSsize; i++) ent_q[i] <= '0;
    end else begin
      count_q <= count_d;
      for (int unsigned i = 0; i < RSsize; i++) ent_q[i] <= nxt[i];
    end
  end

endmodule

// File: tb/tb_mult_reservation_station.sv
// tb_mult_reservation_station
//   Directed bench for mult_reservation_station: reset, single issue,
//   CDB wakeup, oldest-first with collapse, full/stall, dispatch/CDB
//   collision, capture during shift, flush and asynchronous reset.
module tb_mult_reservation_station;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic        dispatchValid_i;
  logic [9:0]  dispatchCommands_i;
  logic [3:0]  dispatchTag_i;
  logic [63:0] dispatchVal1_i, dispatchVal2_i;
  logic        dispatchRdy1_i, dispatchRdy2_i;
  logic [3:0]  dispatchSrc1_i, dispatchSrc2_i;
  logic        full_o;
  logic [2:0]  count_o;
  logic        cdbValid_i;
  logic [3:0]  cdbTag_i;
  logic [63:0] cdbVal_i;
  logic        flush_i;
  logic        readyRS_o;
  logic [63:0] reservationStationVal1_o, reservationStationVal2_o;
  logic [9:0]  reservationStationCommands_o;
  logic [3:0]  reservationStationTag_o;
  logic        stallRS_i;

  int total = 0;
  int bad   = 0;

  mult_reservation_station #(.ROBsize(8), .RSsize(4)) dut (
    .clk_i(clk_i), .reset_i(reset_i),
    .dispatchValid_i(dispatchValid_i), .dispatchCommands_i(dispatchCommands_i),
    .dispatchTag_i(dispatchTag_i),
    .dispatchVal1_i(dispatchVal1_i), .dispatchVal2_i(dispatchVal2_i),
    .dispatchRdy1_i(dispatchRdy1_i), .dispatchRdy2_i(dispatchRdy2_i),
    .dispatchSrc1_i(dispatchSrc1_i), .dispatchSrc2_i(dispatchSrc2_i),
    .full_o(full_o), .count_o(count_o),
    .cdbValid_i(cdbValid_i), .cdbTag_i(cdbTag_i), .cdbVal_i(cdbVal_i),
    .flush_i(flush_i), .readyRS_o(readyRS_o),
    .reservationStationVal1_o(reservationStationVal1_o),
    .reservationStationVal2_o(reservationStationVal2_o),
    .reservationStationCommands_o(reservationStationCommands_o),
    .reservationStationTag_o(reservationStationTag_o),
    .stallRS_i(stallRS_i)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle_inputs();
    dispatchValid_i = 1'b0; dispatchCommands_i = '0; dispatchTag_i = '0;
    dispatchVal1_i = '0; dispatchVal2_i = '0; dispatchRdy1_i = 1'b0; dispatchRdy2_i = 1'b0;
    dispatchSrc1_i = '0; dispatchSrc2_i = '0;
    cdbValid_i = 1'b0; cdbTag_i = '0; cdbVal_i = '0; flush_i = 1'b0;
  endtask

  task automatic set_dispatch(input logic [3:0] tag, input logic [63:0] v1, input logic r1,
                              input logic [3:0] s1, input logic [63:0] v2, input logic r2,
                              input logic [3:0] s2, input logic [9:0] cmd);
    dispatchValid_i = 1'b1; dispatchTag_i = tag; dispatchCommands_i = cmd;
    dispatchVal1_i = v1; dispatchRdy1_i = r1; dispatchSrc1_i = s1;
    dispatchVal2_i = v2; dispatchRdy2_i = r2; dispatchSrc2_i = s2;
  endtask

  task automatic test_reset();
    reset_i = 1'b1; stallRS_i = 1'b0;
    idle_inputs();
    step(); step();
    total++; if (readyRS_o !== 1'b0) begin bad++; $display("FAIL reset_ready got=%0h exp=0", readyRS_o); end
    total++; if (count_o !== 3'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", count_o); end
    total++; if (full_o !== 1'b0) begin bad++; $display("FAIL reset_full got=%0h exp=0", full_o); end
    total++; if (reservationStationVal1_o !== 64'd0 || reservationStationTag_o !== 4'd0)
      begin bad++; $display("FAIL reset_data got=%0h/%0h exp=0/0", reservationStationVal1_o, reservationStationTag_o); end
    reset_i = 1'b0;
    step();
  endtask

  task automatic test_single_issue();
    set_dispatch(4'd3, 64'd5, 1'b1, 4'd0, 64'd7, 1'b1, 4'd0, 10'h155);
    total++; if (readyRS_o !== 1'b0) begin bad++; $display("FAIL single_nobypass got=%0h exp=0", readyRS_o); end
    step();
    idle_inputs();
    total++; if (readyRS_o !== 1'b1) begin bad++; $display("FAIL single_ready got=%0h exp=1", readyRS_o); end
    total++; if (reservationStationVal1_o !== 64'd5) begin bad++; $display("FAIL single_val1 got=%0h exp=5", reservationStationVal1_o); end
    total++; if (reservationStationVal2_o !== 64'd7) begin bad++; $display("FAIL single_val2 got=%0h exp=7", reservationStationVal2_o); end
    total++; if (reservationStationTag_o !== 4'd3) begin bad++; $display("FAIL single_tag got=%0h exp=3", reservationStationTag_o); end
    total++; if (reservationStationCommands_o !== 10'h155) begin bad++; $display("FAIL single_cmd got=%0h exp=155", reservationStationCommands_o); end
    total++; if (count_o !== 3'd1) begin bad++; $display("FAIL single_count1 got=%0d exp=1", count_o); end
    step();
    total++; if (count_o !== 3'd0) begin bad++; $display("FAIL single_count0 got=%0d exp=0", count_o); end
    total++; if (readyRS_o !== 1'b0 || reservationStationVal1_o !== 64'd0)
      begin bad++; $display("FAIL single_gone got=%0h/%0h exp=0/0", readyRS_o, reservationStationVal1_o); end
  endtask

  task automatic test_wakeup();
    set_dispatch(4'd2, 64'd0, 1'b0, 4'd6, 64'd9, 1'b1, 4'd0, 10'h0A1);
    step();
    idle_inputs();
    total++; if (readyRS_o !== 1'b0 || count_o !== 3'd1)
      begin bad++; $display("FAIL wake_wait got=%0h/%0d exp=0/1", readyRS_o, count_o); end
    step();
    cdbValid_i = 1'b1; cdbTag_i = 4'd6; cdbVal_i = 64'h1234;
    total++; if (readyRS_o !== 1'b0) begin bad++; $display("FAIL wake_nobypass got=%0h exp=0", readyRS_o); end
    step();
    idle_inputs();
    total++; if (readyRS_o !== 1'b1) begin bad++; $display("FAIL wake_ready got=%0h exp=1", readyRS_o); end
    total++; if (reservationStationVal1_o !== 64'h1234) begin bad++; $display("FAIL wake_val1 got=%0h exp=1234", reservationStationVal1_o); end
    total++; if (reservationStationVal2_o !== 64'd9 || reservationStationTag_o !== 4'd2)
      begin bad++; $display("FAIL wake_val2tag got=%0h/%0h exp=9/2", reservationStationVal2_o, reservationStationTag_o); end
    step();
    total++; if (count_o !== 3'd0) begin bad++; $display("FAIL wake_count got=%0d exp=0", count_o); end
  endtask

  task automatic test_oldest_first();
    stallRS_i = 1'b1;
    set_dispatch(4'd1, 64'd0, 1'b0, 4'd5, 64'd11, 1'b1, 4'd0, 10'h001); step();
    set_dispatch(4'd2, 64'd21, 1'b1, 4'd0, 64'd22, 1'b1, 4'd0, 10'h002); step();
    set_dispatch(4'd3, 64'd31, 1'b1, 4'd0, 64'd32, 1'b1, 4'd0, 10'h003); step();
    idle_inputs();
    total++; if (count_o !== 3'd3 || reservationStationTag_o !== 4'd2)
      begin bad++; $display("FAIL oldest_b got=%0d/%0h exp=3/2", count_o, reservationStationTag_o); end
    stallRS_i = 1'b0;
    step();
    total++; if (count_o !== 3'd2 || reservationStationTag_o !== 4'd3 || reservationStationVal1_o !== 64'd31)
      begin bad++; $display("FAIL oldest_c got=%0d/%0h/%0h exp=2/3/31", count_o, reservationStationTag_o, reservationStationVal1_o); end
    step();
    total++; if (count_o !== 3'd1 || readyRS_o !== 1'b0)
      begin bad++; $display("FAIL oldest_a_wait got=%0d/%0h exp=1/0", count_o, readyRS_o); end
    cdbValid_i = 1'b1; cdbTag_i = 4'd5; cdbVal_i = 64'hAA;
    step();
    idle_inputs();
    total++; if (readyRS_o !== 1'b1 || reservationStationTag_o !== 4'd1 || reservationStationVal1_o !== 64'hAA)
      begin bad++; $display("FAIL oldest_a got=%0h/%0h/%0h exp=1/1/aa", readyRS_o, reservationStationTag_o, reservationStationVal1_o); end
    step();
    total++; if (count_o !== 3'd0) begin bad++; $display("FAIL oldest_count got=%0d exp=0", count_o); end
  endtask

  task automatic test_full_stall();
    stallRS_i = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      set_dispatch(4'(i), 64'(10 + i), 1'b1, 4'd0, 64'(20 + i), 1'b1, 4'd0, 10'(i));
      step();
    end
    total++; if (full_o !== 1'b1 || count_o !== 3'd4)
      begin bad++; $display("FAIL full_set got=%0h/%0d exp=1/4", full_o, count_o); end
    total++; if (reservationStationTag_o !== 4'd1 || reservationStationVal1_o !== 64'd11)
      begin bad++; $display("FAIL full_hold got=%0h/%0h exp=1/b", reservationStationTag_o, reservationStationVal1_o); end
    // Dispatch while full and issuing: registered full must still drop it.
    set_dispatch(4'd6, 64'd66, 1'b1, 4'd0, 64'd66, 1'b1, 4'd0, 10'h3FF);
    stallRS_i = 1'b0;
    step();
    idle_inputs();
    total++; if (count_o !== 3'd3 || full_o !== 1'b0 || reservationStationTag_o !== 4'd2)
      begin bad++; $display("FAIL full_issue1 got=%0d/%0h/%0h exp=3/0/2", count_o, full_o, reservationStationTag_o); end
    step();
    total++; if (reservationStationTag_o !== 4'd3 || reservationStationVal2_o !== 64'd23)
      begin bad++; $display("FAIL full_issue2 got=%0h/%0h exp=3/17", reservationStationTag_o, reservationStationVal2_o); end
    step();
    total++; if (reservationStationTag_o !== 4'd4 || count_o !== 3'd1)
      begin bad++; $display("FAIL full_issue3 got=%0h/%0d exp=4/1", reservationStationTag_o, count_o); end
    step();
    total++; if (count_o !== 3'd0 || readyRS_o !== 1'b0)
      begin bad++; $display("FAIL full_drain got=%0d/%0h exp=0/0", count_o, readyRS_o); end
  endtask

  task automatic test_collision();
    set_dispatch(4'd7, 64'd3, 1'b1, 4'd0, 64'd0, 1'b0, 4'd4, 10'h077);
    cdbValid_i = 1'b1; cdbTag_i = 4'd4; cdbVal_i = 64'd77;
    step();
    idle_inputs();
    total++; if (readyRS_o !== 1'b1 || reservationStationVal2_o !== 64'd77 || reservationStationTag_o !== 4'd7)
      begin bad++; $display("FAIL collide got=%0h/%0d/%0h exp=1/77/7", readyRS_o, reservationStationVal2_o, reservationStationTag_o); end
    step();
    total++; if (count_o !== 3'd0) begin bad++; $display("FAIL collide_count got=%0d exp=0", count_o); end
  endtask

  task automatic test_capture_shift();
    stallRS_i = 1'b1;
    set_dispatch(4'd1, 64'd1, 1'b1, 4'd0, 64'd1, 1'b1, 4'd0, 10'h011); step();
    set_dispatch(4'd2, 64'd0, 1'b0, 4'd3, 64'd0, 1'b0, 4'd3, 10'h022); step();
    idle_inputs();
    stallRS_i = 1'b0;
    cdbValid_i = 1'b1; cdbTag_i = 4'd3; cdbVal_i = 64'h55;
    step();
    idle_inputs();
    total++; if (count_o !== 3'd1 || readyRS_o !== 1'b1 || reservationStationTag_o !== 4'd2)
      begin bad++; $display("FAIL shiftcap_sel got=%0d/%0h/%0h exp=1/1/2", count_o, readyRS_o, reservationStationTag_o); end
    total++; if (reservationStationVal1_o !== 64'h55 || reservationStationVal2_o !== 64'h55)
      begin bad++; $display("FAIL shiftcap_vals got=%0h/%0h exp=55/55", reservationStationVal1_o, reservationStationVal2_o); end
    step();
  endtask

  task automatic test_flush();
    stallRS_i = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      set_dispatch(4'(i), 64'(i), 1'b1, 4'd0, 64'(i), 1'b1, 4'd0, 10'(i));
      step();
    end
    total++; if (count_o !== 3'd3) begin bad++; $display("FAIL flush_pre got=%0d exp=3", count_o); end
    set_dispatch(4'd9, 64'd9, 1'b1, 4'd0, 64'd9, 1'b1, 4'd0, 10'h009);
    flush_i = 1'b1;
    step();
    idle_inputs();
    total++; if (count_o !== 3'd0 || readyRS_o !== 1'b0 || full_o !== 1'b0)
      begin bad++; $display("FAIL flush_clear got=%0d/%0h/%0h exp=0/0/0", count_o, readyRS_o, full_o); end
    step();
    total++; if (count_o !== 3'd0 || reservationStationTag_o !== 4'd0)
      begin bad++; $display("FAIL flush_drop got=%0d/%0h exp=0/0", count_o, reservationStationTag_o); end
    stallRS_i = 1'b0;
  endtask

  task automatic test_async_reset();
    stallRS_i = 1'b1;
    set_dispatch(4'd5, 64'd50, 1'b1, 4'd0, 64'd51, 1'b1, 4'd0, 10'h050);
    step();
    idle_inputs();
    total++; if (readyRS_o !== 1'b1 || reservationStationVal1_o !== 64'd50)
      begin bad++; $display("FAIL areset_pre got=%0h/%0h exp=1/32", readyRS_o, reservationStationVal1_o); end
    #1;
    reset_i = 1'b1;
    #1;
    total++; if (readyRS_o !== 1'b0 || count_o !== 3'd0 || reservationStationVal1_o !== 64'd0)
      begin bad++; $display("FAIL areset_now got=%0h/%0d/%0h exp=0/0/0", readyRS_o, count_o, reservationStationVal1_o); end
    step();
    reset_i = 1'b0;
    stallRS_i = 1'b0;
    step();
    total++; if (count_o !== 3'd0 || full_o !== 1'b0)
      begin bad++; $display("FAIL areset_post got=%0d/%0h exp=0/0", count_o, full_o); end
  endtask

  initial begin
    test_reset();
    test_single_issue();
    test_wakeup();
    test_oldest_first();
    test_full_stall();
    test_collision();
    test_capture_shift();
    test_flush();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
